// File: rtl/rom_copy_pkg.sv
// Purpose: shared types and constants for the ROM-to-BSRAM boot copy engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rom_copy_pkg;

    // Bus data width; kept equal to SCR1_AHB_WIDTH of the core's AHB fabric.
    localparam int DW = 32;

    // AHB HTRANS encodings used by the requester.
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIN  = 2'b10
    } state_t;

endpackage

// File: rtl/rom_copy_skid.sv
// Purpose: 1-entry skid between ROM read data and the destination write port.
// Latency: 0 cycles (bypass) when empty; the parked word is presented first when occupied.
// Backpressure: a word offered while dn_rdy=0 is parked; upstream must not offer while parked and stalled.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   up_vld, up_dat    incoming word (ROM data landing this cycle)
//   dn_vld, dn_dat    word presented downstream (destination write)
//   dn_rdy            downstream accepts when dn_vld & dn_rdy
//   skid_vld          a word is parked in the skid register
module rom_copy_skid #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          up_vld,
    input  logic [DW-1:0] up_dat,
    output logic          dn_vld,
    output logic [DW-1:0] dn_dat,
    input  logic          dn_rdy,
    output logic          skid_vld
);

    logic [DW-1:0] skid_dat;

    // Parked word always wins so write order is preserved.
    assign dn_vld = skid_vld | up_vld;
    assign dn_dat = skid_vld ? skid_dat : up_dat;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            skid_vld <= 1'b0;
            skid_dat <= '0;
        end else begin
            // Whatever is presented but not accepted stays parked.
            skid_vld <= dn_vld & ~dn_rdy;
            if (!skid_vld || dn_rdy) begin
                skid_dat <= up_dat;
            end
        end
    end

endmodule

// File: rtl/rom_copy_initiator.sv
// Purpose: copies len words from the ROM dmem port into a writable BSRAM at boot.
// Latency: start -> first ROM issue 1 cycle; issue -> write 1 cycle min; 1 word/cycle sustained.
// Backpressure: wr_ready=0 parks one word in the skid and stalls further ROM issues.
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   start, src_base, dst_base, len   copy request (sampled in IDLE only)
//   busy, done, err                  status: in progress / completion pulse / sticky abort flag
//   rom_addr, rom_trans, rom_hsel,
//   rom_hready_in                    ROM request (asserted on issue cycle only)
//   rom_ready, rom_resp, rom_data    ROM response (data cycle follows issue)
//   wr_en, wr_addr, wr_data, wr_ready destination write port
module rom_copy_initiator
    import rom_copy_pkg::*;
#(
    parameter int SRC_WORDS = 64,
    parameter int SRC_AW    = $clog2(SRC_WORDS),
    parameter int DST_AW    = 12,
    parameter int DW        = rom_copy_pkg::DW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [SRC_AW-1:0] src_base,
    input  logic [DST_AW-1:0] dst_base,
    input  logic [DST_AW:0]   len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [SRC_AW-1:0] rom_addr,
    output logic [1:0]        rom_trans,
    output logic              rom_hsel,
    output logic              rom_hready_in,
    input  logic              rom_ready,
    input  logic              rom_resp,
    input  logic [DW-1:0]     rom_data,
    output logic              wr_en,
    output logic [DST_AW-1:0] wr_addr,
    output logic [DW-1:0]     wr_data,
    input  logic              wr_ready
);

    localparam int CW = DST_AW + 1;

    state_t            state_q, state_d;
    logic [SRC_AW-1:0] src_base_q;
    logic [DST_AW-1:0] dst_base_q;
    logic [CW-1:0]     len_q;
    logic [CW-1:0]     rd_cnt_q;
    logic [CW-1:0]     wr_cnt_q;
    logic [CW-1:0]     wr_cnt_nxt;
    logic              infl_q;
    logic              infl_nxt;
    logic              abort_q;
    logic              err_q;
    logic              done_q;

    logic              land;
    logic              land_err;
    logic              abort;
    logic              issue;
    logic              wr_accept;
    logic              skid_vld;
    logic              start_ok;

    assign start_ok  = (state_q == IDLE) & start;
    assign land      = infl_q & rom_ready;
    assign land_err  = land & rom_resp;
    // An error landing this cycle already suppresses the issue in the same cycle.
    assign abort     = abort_q | land_err;
    assign wr_accept = wr_en & wr_ready;
    assign wr_cnt_nxt = wr_cnt_q + CW'(wr_accept);

    // A new read may go out only if its data is guaranteed a place to land:
    // skid empty and the current in-flight word (if any) is leaving this cycle.
    assign issue = (state_q == RUN) && (rd_cnt_q < len_q) && !skid_vld &&
                   !(infl_q && !(land && wr_ready)) && !abort;

    assign infl_nxt = issue | (infl_q & ~land);

    // Errored data never enters the skid.
    rom_copy_skid #(
        .DW (DW)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .up_vld   (land & ~rom_resp),
        .up_dat   (rom_data),
        .dn_vld   (wr_en),
        .dn_dat   (wr_data),
        .dn_rdy   (wr_ready),
        .skid_vld (skid_vld)
    );

    assign rom_addr      = src_base_q + SRC_AW'(rd_cnt_q);
    assign rom_trans     = issue ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign rom_hsel      = issue;
    assign rom_hready_in = issue;
    assign wr_addr       = dst_base_q + DST_AW'(wr_cnt_q);

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign err  = err_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (len == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                // Abort finishes once nothing is in flight and no word remains parked.
                if ((wr_cnt_nxt == len_q) ||
                    (abort && !infl_nxt && !(wr_en && !wr_ready))) begin
                    state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            src_base_q <= '0;
            dst_base_q <= '0;
            len_q      <= '0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            infl_q     <= 1'b0;
            abort_q    <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == FIN);
            infl_q  <= infl_nxt;
            if (start_ok) begin
                src_base_q <= src_base;
                dst_base_q <= dst_base;
                len_q      <= len;
                rd_cnt_q   <= '0;
                wr_cnt_q   <= '0;
                abort_q    <= 1'b0;
                err_q      <= 1'b0;
            end else begin
                if (issue) begin
                    rd_cnt_q <= rd_cnt_q + 1'b1;
                end
                wr_cnt_q <= wr_cnt_nxt;
                if (land_err) begin
                    abort_q <= 1'b1;
                    err_q   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rom_copy_initiator.sv
// Purpose: directed self-checking bench for rom_copy_initiator with a 1-cycle ROM model.
// Latency: n/a.
// Backpressure: wr_ready driven per cycle from the stimulus task.
module tb_rom_copy_initiator;
    import rom_copy_pkg::*;

    localparam int SRC_WORDS = 64;
    localparam int SRC_AW    = 6;
    localparam int DST_AW    = 12;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [SRC_AW-1:0] src_base;
    logic [DST_AW-1:0] dst_base;
    logic [DST_AW:0]   len;
    logic              busy, done, err;
    logic [SRC_AW-1:0] rom_addr;
    logic [1:0]        rom_trans;
    logic              rom_hsel, rom_hready_in;
    logic              rom_ready, rom_resp;
    logic [31:0]       rom_data;
    logic              wr_en;
    logic [DST_AW-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              wr_ready;

    always #5 clk = ~clk;

    rom_copy_initiator #(
        .SRC_WORDS (SRC_WORDS),
        .DST_AW    (DST_AW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .src_base      (src_base),
        .dst_base      (dst_base),
        .len           (len),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .rom_addr      (rom_addr),
        .rom_trans     (rom_trans),
        .rom_hsel      (rom_hsel),
        .rom_hready_in (rom_hready_in),
        .rom_ready     (rom_ready),
        .rom_resp      (rom_resp),
        .rom_data      (rom_data),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready)
    );

    function automatic logic [31:0] rom_word(input int a);
        return 32'(a) * 32'h1111_1111;
    endfunction

    // ROM responder: data in the cycle after issue, optional wait states / error on one read.
    logic              pend = 1'b0;
    logic [SRC_AW-1:0] paddr = '0;
    int                pnum = 0;
    int                tot_issue = 0;
    int                stall_cnt = 0;
    int                stall_abs = -1;
    int                stall_n = 0;
    int                err_abs = -1;

    assign rom_ready = !(pend && pnum == stall_abs && stall_cnt < stall_n);
    assign rom_resp  = pend && (pnum == err_abs);
    assign rom_data  = pend ? rom_word(int'(paddr)) : 32'h0;

    always @(posedge clk) begin
        if (!rst_n) begin
            pend      <= 1'b0;
            stall_cnt <= 0;
        end else begin
            if (pend && rom_ready) begin
                pend      <= 1'b0;
                stall_cnt <= 0;
            end else if (pend) begin
                stall_cnt <= stall_cnt + 1;
            end
            if (rom_hsel && rom_hready_in && rom_trans == HTRANS_NONSEQ) begin
                pend      <= 1'b1;
                paddr     <= rom_addr;
                pnum      <= tot_issue;
                tot_issue <= tot_issue + 1;
            end
        end
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int done_cyc, busy_n, done_n, n_issue, n_wr, first_iss, last_iss, w2_cyc;
    logic err_c1;

    // Cycle c is the interval after the c-th rising edge; start is high in cycle 0.
    task automatic run_copy(input int src, input int dst, input int ln,
                            input int wlo_a, input int wlo_b);
        done_cyc = -1; busy_n = 0; done_n = 0; n_issue = 0; n_wr = 0;
        first_iss = -1; last_iss = -1; w2_cyc = -1; err_c1 = 1'bx;
        for (int c = 0; c <= 300; c++) begin
            @(posedge clk);
            #1;
            start    = (c == 0);
            src_base = SRC_AW'(src);
            dst_base = DST_AW'(dst);
            len      = (DST_AW + 1)'(ln);
            wr_ready = !(c >= wlo_a && c <= wlo_b);
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (rom_trans != HTRANS_IDLE) begin
                check("iss_addr", 64'(rom_addr), 64'((src + n_issue) % SRC_WORDS));
                if (first_iss < 0) first_iss = c;
                last_iss = c;
                n_issue++;
            end
            if (wr_en && wr_ready) begin
                check("wr_addr", 64'(wr_addr), 64'((dst + n_wr) % 4096));
                check("wr_data", 64'(wr_data), 64'(rom_word((src + n_wr) % SRC_WORDS)));
                if (n_wr == 2) w2_cyc = c;
                n_wr++;
            end
            if (c == 1) err_c1 = err;
            if (done_cyc >= 0 && c >= done_cyc + 1) break;
        end
        start = 1'b0;
        check("done_pulses", 64'(done_n), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  64'(busy), 64'd0);
        check({tag, "_done"},  64'(done), 64'd0);
        check({tag, "_err"},   64'(err), 64'd0);
        check({tag, "_trans"}, 64'(rom_trans), 64'(HTRANS_IDLE));
        check({tag, "_hsel"},  64'(rom_hsel), 64'd0);
        check({tag, "_hrdy"},  64'(rom_hready_in), 64'd0);
        check({tag, "_wr_en"}, 64'(wr_en), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; src_base = '0; dst_base = '0; len = '0; wr_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Back-to-back copy of 8 words.
        run_copy(4, 'h100, 8, -1, -1);
        check("t1_issues", 64'(n_issue), 64'd8);
        check("t1_first_iss", 64'(first_iss), 64'd1);
        check("t1_last_iss", 64'(last_iss), 64'd8);
        check("t1_writes", 64'(n_wr), 64'd8);
        check("t1_done_cyc", 64'(done_cyc), 64'd11);
        check("t1_busy_cycles", 64'(busy_n), 64'd10);
        check("t1_err", 64'(err), 64'd0);

        // Zero-length copy: no ROM traffic.
        run_copy(0, 'h10, 0, -1, -1);
        check("t2_issues", 64'(n_issue), 64'd0);
        check("t2_writes", 64'(n_wr), 64'd0);
        check("t2_done_cyc", 64'(done_cyc), 64'd2);
        check("t2_busy_cycles", 64'(busy_n), 64'd1);

        // Destination backpressure in cycles 3..6.
        run_copy(10, 'h200, 6, 3, 6);
        check("t3_writes", 64'(n_wr), 64'd6);
        check("t3_issues", 64'(n_issue), 64'd6);
        check("t3_done_cyc", 64'(done_cyc), 64'd14);

        // Two ROM wait states on the third read.
        stall_abs = tot_issue + 2;
        stall_n   = 2;
        run_copy(0, 'h20, 4, -1, -1);
        stall_abs = -1;
        check("t4_w2_cyc", 64'(w2_cyc), 64'd6);
        check("t4_writes", 64'(n_wr), 64'd4);
        check("t4_done_cyc", 64'(done_cyc), 64'd9);

        // ROM error on word 5 of 10.
        err_abs = tot_issue + 5;
        run_copy(20, 'h300, 10, -1, -1);
        err_abs = -1;
        check("t5_writes", 64'(n_wr), 64'd5);
        check("t5_issues", 64'(n_issue), 64'd6);
        check("t5_done_cyc", 64'(done_cyc), 64'd9);
        check("t5_err", 64'(err), 64'd1);

        // Source and destination address wrap; start clears err.
        run_copy(SRC_WORDS - 2, 'hFFE, 4, -1, -1);
        check("t6_err_cleared", 64'(err_c1), 64'd0);
        check("t6_writes", 64'(n_wr), 64'd4);
        check("t6_issues", 64'(n_issue), 64'd4);
        check("t6_done_cyc", 64'(done_cyc), 64'd7);

        // Reset in the middle of a copy.
        @(posedge clk); #1;
        start = 1'b1; src_base = '0; dst_base = '0; len = 13'd8; wr_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("t7_busy_before", 64'(busy), 64'd1);
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("t7");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("t7_idle_after", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
